// File: rtl/cmd_proc_if.sv
// ---------------------------------------------------------------------------
// cmd_proc_if : bus bundle between the USB/ADC/TX-buffer side and cmd_proc.
//   RX path   : rx_vd, rx_sop, rx_eop, rx_data   (into cmd_proc)
//   ADC path  : ad_switch, ad_data (into), ad_rd, ad_chn, ad_acq_en (out)
//   TX buffer : tx_vd, tx_addr, tx_data, tx_eop, tx_baddr (out)
//   Status    : overrun_cnt (out)
// Modports: slave = cmd_proc side, master = environment side.
// ---------------------------------------------------------------------------
interface cmd_proc_if #(
   parameter int DATA_W  = 16,
   parameter int CHN_W   = 3,
   parameter int ADDR_W  = 9,
   parameter int BADDR_W = 2
);
   logic                      rx_vd;
   logic                      rx_sop;
   logic                      rx_eop;
   logic [DATA_W-1:0]         rx_data;
   logic                      ad_switch;
   logic [DATA_W-1:0]         ad_data;
   logic                      ad_rd;
   logic [CHN_W-1:0]          ad_chn;
   logic                      ad_acq_en;
   logic                      tx_vd;
   logic [BADDR_W+ADDR_W-1:0] tx_addr;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_eop;
   logic [BADDR_W-1:0]        tx_baddr;
   logic [7:0]                overrun_cnt;

   modport slave (
      input  rx_vd, rx_sop, rx_eop, rx_data, ad_switch, ad_data,
      output ad_rd, ad_chn, ad_acq_en, tx_vd, tx_addr, tx_data, tx_eop,
             tx_baddr, overrun_cnt
   );

   modport master (
      output rx_vd, rx_sop, rx_eop, rx_data, ad_switch, ad_data,
      input  ad_rd, ad_chn, ad_acq_en, tx_vd, tx_addr, tx_data, tx_eop,
             tx_baddr, overrun_cnt
   );
endinterface

// File: rtl/cmd_proc.sv
// ---------------------------------------------------------------------------
// cmd_proc : USB command decoder / ADC frame builder.
//   mclk, rst : clock and synchronous active-high reset
//   bus       : cmd_proc_if.slave (RX command words in, ADC control out,
//               TX ping-pong buffer writes out, overrun counter out)
// An RX FSM decodes {HEAD, type, channel} frames into a one-cycle command
// strobe. A TX FSM writes either 4-word acknowledge frames (base 0) or full
// data frames (rotating base 1..2^BADDR_W-1) into the TX buffer.
// ---------------------------------------------------------------------------
module cmd_proc #(
   parameter int DATA_W     = 16,
   parameter int N_CHN      = 8,
   parameter int CHN_W      = 3,
   parameter int DATA_WORDS = 256,
   parameter int CNT_WORDS  = 2,
   parameter int ADDR_W     = 9,
   parameter int BADDR_W    = 2,
   parameter int RX_TIMEOUT = 4096
)(
   input logic      mclk,
   input logic      rst,
   cmd_proc_if.slave bus
);
   localparam int CNT_W = CNT_WORDS * DATA_W;
   localparam int TMR_W = $clog2(RX_TIMEOUT);

   // Two-char ASCII words; the first char sits in the low byte.
   localparam logic [DATA_W-1:0] MSG_HEAD       = DATA_W'(16'h55AA);
   localparam logic [DATA_W-1:0] MSG_TYPE_HS    = DATA_W'(16'h3030); // "00"
   localparam logic [DATA_W-1:0] MSG_TYPE_START = DATA_W'(16'h3130); // "01"
   localparam logic [DATA_W-1:0] MSG_TYPE_STOP  = DATA_W'(16'h3230); // "02"
   localparam logic [DATA_W-1:0] MSG_PASS       = DATA_W'(16'h4B4F); // "OK"
   localparam logic [DATA_W-1:0] MSG_FAIL       = DATA_W'(16'h5245); // "ER"
   localparam logic [DATA_W-1:0] CODE_01        = DATA_W'(16'h3130);
   localparam logic [DATA_W-1:0] CODE_02        = DATA_W'(16'h3230);
   localparam logic [DATA_W-1:0] CODE_11        = DATA_W'(16'h3131);
   localparam logic [DATA_W-1:0] CODE_12        = DATA_W'(16'h3231);
   localparam logic [DATA_W-1:0] CODE_EE        = DATA_W'(16'h4545);
   localparam logic [7:0]        MSG_END_N      = 8'h0A;
   localparam logic [7:0]        MSG_END_R      = 8'h0D;
   localparam logic [DATA_W-1:0] MSG_END        = DATA_W'({MSG_END_N, MSG_END_R});

   // Word positions inside a frame.
   localparam logic [ADDR_W-1:0] IDX_CODE = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] IDX_CHN  = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] IDX_CNT0 = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] IDX_DAT0 = ADDR_W'(5 + CNT_WORDS);
   localparam logic [ADDR_W-1:0] IDX_DATN = ADDR_W'(4 + CNT_WORDS + DATA_WORDS);
   localparam logic [ADDR_W-1:0] IDX_END  = ADDR_W'(5 + CNT_WORDS + DATA_WORDS);
   // ad_rd leads the data word it fetches by two cycles (ADC latency + tx reg).
   localparam logic [ADDR_W-1:0] IDX_RD0  = ADDR_W'(3 + CNT_WORDS);
   localparam logic [ADDR_W-1:0] IDX_RDN  = ADDR_W'(2 + CNT_WORDS + DATA_WORDS);
   localparam logic [ADDR_W-1:0] IDX_LAST = '1;

   function automatic logic [4:0] hex_dec(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= 8'h30 && c <= 8'h39)
         r = {1'b1, c[3:0]};
      else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
         r = {1'b1, c[3:0] + 4'd9};
      return r;
   endfunction

   function automatic logic [7:0] hex_enc(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
      for (int b = 0; b < DATA_W/8; b++)
         r[b*8 +: 8] = w[DATA_W-8-b*8 +: 8];
      return r;
   endfunction

   // ---------------------------------------------------------------- RX FSM
   typedef enum logic [2:0] {RX_IDLE, RX_HEAD, RX_TYPE, RX_CHADDR, RX_END} rx_state_t;

   rx_state_t         rx_state_q;
   logic [TMR_W-1:0]  rx_tmr_q;
   logic [DATA_W-1:0] type_q;
   logic [CHN_W-1:0]  chn_q;
   logic              err_q;
   logic              cmd_q;

   logic [4:0] hi_dec, lo_dec;
   logic [7:0] chaddr_val;
   logic       chaddr_bad;

   assign hi_dec     = hex_dec(bus.rx_data[7:0]);
   assign lo_dec     = hex_dec(bus.rx_data[15:8]);
   assign chaddr_val = {hi_dec[3:0], lo_dec[3:0]};
   assign chaddr_bad = !hi_dec[4] || !lo_dec[4] || (chaddr_val >= 8'(N_CHN));

   always_ff @(posedge mclk) begin
      if (rst) begin
         rx_state_q <= RX_IDLE;
         rx_tmr_q   <= '0;
         type_q     <= '0;
         chn_q      <= '0;
         err_q      <= 1'b0;
         cmd_q      <= 1'b0;
      end else begin
         cmd_q <= 1'b0;
         if (bus.rx_sop) begin
            rx_state_q <= RX_HEAD;
            rx_tmr_q   <= '0;
            err_q      <= 1'b0;
         end else if (rx_state_q != RX_IDLE) begin
            if (!bus.rx_vd && !bus.rx_eop) begin
               // Stalled frame: give up silently after RX_TIMEOUT idle cycles.
               if (rx_tmr_q == TMR_W'(RX_TIMEOUT - 1)) begin
                  rx_state_q <= RX_IDLE;
                  rx_tmr_q   <= '0;
               end else begin
                  rx_tmr_q <= rx_tmr_q + 1'b1;
               end
            end else begin
               rx_tmr_q <= '0;
               case (rx_state_q)
                  RX_HEAD:   if (bus.rx_vd && bus.rx_data == MSG_HEAD) rx_state_q <= RX_TYPE;
                  RX_TYPE:   if (bus.rx_vd) begin
                                type_q     <= bus.rx_data;
                                rx_state_q <= RX_CHADDR;
                             end
                  RX_CHADDR: if (bus.rx_vd) begin
                                chn_q      <= chaddr_val[CHN_W-1:0];
                                err_q      <= chaddr_bad;
                                rx_state_q <= RX_END;
                             end
                  RX_END:    if (bus.rx_eop) begin
                                cmd_q      <= 1'b1;
                                rx_state_q <= RX_IDLE;
                             end
                  default:   rx_state_q <= RX_IDLE;
               endcase
            end
         end
      end
   end

   // ---------------------------------------------------------------- TX FSM
   typedef enum logic [1:0] {TX_IDLE, TX_ACK, TX_DATA} tx_state_t;

   tx_state_t          tx_state_q;
   logic [ADDR_W-1:0]  idx_q;
   logic [BADDR_W-1:0] base_q, rotor_q, tx_baddr_q;
   logic [DATA_W-1:0]  frm_type_q, frm_pf_q, frm_code_q;
   logic [CHN_W-1:0]   frm_chn_q, chn_sel_q;
   logic               ack_pend_q, data_pend_q, acq_en_q;
   logic [DATA_W-1:0]  ack_type_q, ack_pf_q, ack_code_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [7:0]         ovr_q;
   logic               tx_vd_q, tx_eop_q, ad_rd_q;
   logic [BADDR_W+ADDR_W-1:0] tx_addr_q;
   logic [DATA_W-1:0]  tx_data_q;

   logic [BADDR_W-1:0] base_nxt;
   logic               tx_take_data;
   logic [7:0]         chn8;
   logic [DATA_W-1:0]  tx_word_d;
   logic [DATA_W-1:0]  cnt_words [CNT_WORDS];

   assign base_nxt     = (rotor_q == '1) ? BADDR_W'(1) : rotor_q + 1'b1;
   assign tx_take_data = (tx_state_q == TX_IDLE) && !ack_pend_q && data_pend_q;
   assign chn8         = 8'(frm_chn_q);

   // Frame counter split into words, most significant word first.
   genvar gi;
   for (gi = 0; gi < CNT_WORDS; gi++) begin : g_cnt_word
      assign cnt_words[gi] = bswap(cnt_q[(CNT_WORDS-1-gi)*DATA_W +: DATA_W]);
   end

   always_comb begin
      tx_word_d = '0;
      if (idx_q == '0)
         tx_word_d = MSG_HEAD;
      else if (idx_q == ADDR_W'(1))
         tx_word_d = frm_type_q;
      else if (idx_q == ADDR_W'(2))
         tx_word_d = frm_pf_q;
      else if (idx_q == IDX_CODE)
         tx_word_d = frm_code_q;
      else if (idx_q == IDX_CHN)
         tx_word_d = DATA_W'({hex_enc(chn8[3:0]), hex_enc(chn8[7:4])});
      else if (idx_q >= IDX_DAT0 && idx_q <= IDX_DATN)
         tx_word_d = bswap(bus.ad_data);
      else if (idx_q == IDX_END)
         tx_word_d = MSG_END;
      for (int k = 0; k < CNT_WORDS; k++)
         if (idx_q == IDX_CNT0 + ADDR_W'(k))
            tx_word_d = cnt_words[k];
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         tx_state_q  <= TX_IDLE;
         idx_q       <= '0;
         base_q      <= '0;
         rotor_q     <= '0;
         tx_baddr_q  <= '0;
         frm_type_q  <= '0;
         frm_pf_q    <= '0;
         frm_code_q  <= '0;
         frm_chn_q   <= '0;
         chn_sel_q   <= '0;
         ack_pend_q  <= 1'b0;
         data_pend_q <= 1'b0;
         acq_en_q    <= 1'b0;
         ack_type_q  <= '0;
         ack_pf_q    <= '0;
         ack_code_q  <= '0;
         cnt_q       <= '0;
         ovr_q       <= '0;
         tx_vd_q     <= 1'b0;
         tx_eop_q    <= 1'b0;
         ad_rd_q     <= 1'b0;
         tx_addr_q   <= '0;
         tx_data_q   <= '0;
      end else begin
         tx_eop_q <= 1'b0;
         ad_rd_q  <= 1'b0;

         // Frame sequencing. Word 0 is written on the cycle the frame starts.
         case (tx_state_q)
            TX_IDLE: begin
               tx_vd_q <= 1'b0;
               if (ack_pend_q) begin
                  ack_pend_q <= 1'b0;
                  frm_type_q <= ack_type_q;
                  frm_pf_q   <= ack_pf_q;
                  frm_code_q <= ack_code_q;
                  base_q     <= '0;
                  tx_vd_q    <= 1'b1;
                  tx_addr_q  <= '0;
                  tx_data_q  <= MSG_HEAD;
                  idx_q      <= ADDR_W'(1);
                  tx_state_q <= TX_ACK;
               end else if (data_pend_q) begin
                  data_pend_q <= 1'b0;
                  frm_type_q  <= MSG_TYPE_START;
                  frm_pf_q    <= MSG_PASS;
                  frm_code_q  <= CODE_01;
                  frm_chn_q   <= chn_sel_q;
                  base_q      <= base_nxt;
                  rotor_q     <= base_nxt;
                  tx_vd_q     <= 1'b1;
                  tx_addr_q   <= {base_nxt, {ADDR_W{1'b0}}};
                  tx_data_q   <= MSG_HEAD;
                  idx_q       <= ADDR_W'(1);
                  tx_state_q  <= TX_DATA;
               end
            end
            TX_ACK, TX_DATA: begin
               tx_vd_q   <= 1'b1;
               tx_addr_q <= {base_q, idx_q};
               tx_data_q <= tx_word_d;
               idx_q     <= idx_q + 1'b1;
               if (tx_state_q == TX_DATA && idx_q >= IDX_RD0 && idx_q <= IDX_RDN)
                  ad_rd_q <= 1'b1;
               if ((tx_state_q == TX_ACK && idx_q == IDX_CODE) ||
                   (tx_state_q == TX_DATA && idx_q == IDX_LAST)) begin
                  tx_eop_q   <= 1'b1;
                  tx_baddr_q <= base_q;
                  tx_state_q <= TX_IDLE;
                  if (tx_state_q == TX_DATA)
                     cnt_q <= cnt_q + 1'b1;
               end
            end
            default: tx_state_q <= TX_IDLE;
         endcase

         // A block arriving while the previous one is still waiting is dropped.
         if (bus.ad_switch && acq_en_q) begin
            if (data_pend_q && !tx_take_data) begin
               if (ovr_q != 8'hFF)
                  ovr_q <= ovr_q + 8'd1;
            end else begin
               data_pend_q <= 1'b1;
            end
         end

         // Command execution comes last so a fresh ack overrides one being taken.
         if (cmd_q) begin
            ack_pend_q <= 1'b1;
            ack_type_q <= type_q;
            case (type_q)
               MSG_TYPE_HS: begin
                  ack_pf_q   <= MSG_PASS;
                  ack_code_q <= CODE_01;
               end
               MSG_TYPE_START: begin
                  if (!err_q) begin
                     acq_en_q   <= 1'b1;
                     chn_sel_q  <= chn_q;
                     cnt_q      <= '0;
                     ack_pf_q   <= MSG_PASS;
                     ack_code_q <= CODE_01;
                  end else begin
                     ack_pf_q   <= MSG_FAIL;
                     ack_code_q <= CODE_02;
                  end
               end
               MSG_TYPE_STOP: begin
                  acq_en_q    <= 1'b0;
                  data_pend_q <= 1'b0;
                  ack_pf_q    <= err_q ? MSG_FAIL : MSG_PASS;
                  ack_code_q  <= err_q ? CODE_12 : CODE_11;
               end
               default: begin
                  ack_pf_q   <= MSG_FAIL;
                  ack_code_q <= CODE_EE;
               end
            endcase
         end
      end
   end

   assign bus.ad_rd       = ad_rd_q;
   assign bus.ad_chn      = chn_sel_q;
   assign bus.ad_acq_en   = acq_en_q;
   assign bus.tx_vd       = tx_vd_q;
   assign bus.tx_addr     = tx_addr_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.tx_eop      = tx_eop_q;
   assign bus.tx_baddr    = tx_baddr_q;
   assign bus.overrun_cnt = ovr_q;
endmodule

// File: tb/tb_cmd_proc.sv
// ---------------------------------------------------------------------------
// tb_cmd_proc : directed bench for cmd_proc (default parameters).
// Sends command frames, emulates the ADC, captures TX buffer writes into a
// shadow memory and compares frames against hand-computed words.
// ---------------------------------------------------------------------------
module tb_cmd_proc;
   localparam logic [15:0] HEAD     = 16'h55AA;
   localparam logic [15:0] T_HS     = 16'h3030;
   localparam logic [15:0] T_START  = 16'h3130;
   localparam logic [15:0] T_STOP   = 16'h3230;
   localparam logic [15:0] PF_OK    = 16'h4B4F;
   localparam logic [15:0] PF_BAD   = 16'h5245;
   localparam logic [15:0] C01      = 16'h3130;
   localparam logic [15:0] C02      = 16'h3230;
   localparam logic [15:0] C11      = 16'h3131;
   localparam logic [15:0] C12      = 16'h3231;
   localparam logic [15:0] CEE      = 16'h4545;
   localparam logic [15:0] END_W    = 16'h0A0D;
   localparam logic [15:0] ADC_BASE = 16'h1200;

   logic mclk = 1'b0;
   logic rst;
   always #5 mclk = ~mclk;

   cmd_proc_if #(.DATA_W(16), .CHN_W(3), .ADDR_W(9), .BADDR_W(2)) bus_if ();

   cmd_proc #(
      .DATA_W(16), .N_CHN(8), .CHN_W(3), .DATA_WORDS(256), .CNT_WORDS(2),
      .ADDR_W(9), .BADDR_W(2), .RX_TIMEOUT(4096)
   ) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] sw(input logic [15:0] w);
      return {w[7:0], w[15:8]};
   endfunction

   // ADC model: a read strobe returns the next value of a counting sequence.
   int adc_idx = 0;
   always @(posedge mclk) begin
      if (rst) begin
         bus_if.ad_data <= '0;
      end else if (bus_if.ad_rd) begin
         bus_if.ad_data <= ADC_BASE + 16'(adc_idx);
         adc_idx        <= adc_idx + 1;
      end
   end

   // TX buffer shadow and frame monitor.
   logic [15:0] mem [0:2047];
   int          cyc = 0;
   int          eop_cnt = 0;
   int          start_cyc = 0;
   int          eop_len = 0;
   logic [1:0]  last_baddr = '0;
   logic [10:0] last_eop_addr = '0;

   always @(posedge mclk) cyc <= cyc + 1;

   always @(negedge mclk) begin
      if (bus_if.tx_vd) begin
         mem[bus_if.tx_addr] = bus_if.tx_data;
         if (bus_if.tx_addr[8:0] == 9'd0) start_cyc = cyc;
      end
      if (bus_if.tx_eop) begin
         eop_cnt++;
         last_baddr    = bus_if.tx_baddr;
         last_eop_addr = bus_if.tx_addr;
         eop_len       = cyc - start_cyc;
         $display("tx frame: base %0d last addr %0h length %0d", bus_if.tx_baddr,
                  bus_if.tx_addr, eop_len + 1);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   task automatic rx_word(input logic [15:0] w);
      bus_if.rx_vd   = 1'b1;
      bus_if.rx_data = w;
      tick();
      bus_if.rx_vd   = 1'b0;
      bus_if.rx_data = '0;
   endtask

   task automatic rx_sop();
      bus_if.rx_sop = 1'b1;
      tick();
      bus_if.rx_sop = 1'b0;
   endtask

   task automatic rx_eop();
      bus_if.rx_eop = 1'b1;
      tick();
      bus_if.rx_eop = 1'b0;
   endtask

   task automatic send_cmd(input logic [15:0] t, input logic [15:0] c);
      $display("rx cmd: type %h chaddr %h", t, c);
      rx_sop();
      rx_word(HEAD);
      rx_word(t);
      rx_word(c);
      rx_eop();
   endtask

   task automatic ad_pulse();
      bus_if.ad_switch = 1'b1;
      tick();
      bus_if.ad_switch = 1'b0;
   endtask

   task automatic wait_eop(input string tag, input int budget);
      int start_n;
      int n;
      start_n = eop_cnt;
      n = 0;
      while (eop_cnt == start_n && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_eop_seen"}, 32'(eop_cnt > start_n), 32'd1);
   endtask

   task automatic check_ack(input string tag, input logic [15:0] t,
                            input logic [15:0] pf, input logic [15:0] code);
      wait_eop(tag, 50);
      check({tag, "_base"}, last_baddr, 0);
      check({tag, "_eop_addr"}, last_eop_addr, 11'h003);
      check({tag, "_w0"}, mem[0], HEAD);
      check({tag, "_w1"}, mem[1], t);
      check({tag, "_w2"}, mem[2], pf);
      check({tag, "_w3"}, mem[3], code);
   endtask

   task automatic check_data(input string tag, input int base, input logic [15:0] chn_w,
                             input logic [31:0] cnt, input int rd_before);
      int   bad;
      int   a;
      logic [15:0] exp_v;
      wait_eop(tag, 1200);
      a = base * 512;
      check({tag, "_base"}, last_baddr, base);
      check({tag, "_eop_addr"}, last_eop_addr, a + 511);
      check({tag, "_len"}, eop_len, 511);
      check({tag, "_head"}, mem[a], HEAD);
      check({tag, "_type"}, mem[a+1], T_START);
      check({tag, "_pf"}, mem[a+2], PF_OK);
      check({tag, "_code"}, mem[a+3], C01);
      check({tag, "_chn"}, mem[a+4], chn_w);
      check({tag, "_cnt_ms"}, mem[a+5], sw(cnt[31:16]));
      check({tag, "_cnt_ls"}, mem[a+6], sw(cnt[15:0]));
      bad = 0;
      for (int j = 0; j < 256; j++) begin
         exp_v = ADC_BASE + 16'(rd_before + j);
         if (mem[a+7+j] !== sw(exp_v)) bad++;
      end
      check({tag, "_data_bad"}, bad, 0);
      check({tag, "_end"}, mem[a+263], END_W);
      check({tag, "_pad264"}, mem[a+264], 16'h0000);
      check({tag, "_pad511"}, mem[a+511], 16'h0000);
      check({tag, "_rd_cnt"}, adc_idx - rd_before, 256);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      int n;
      rst              = 1'b1;
      bus_if.rx_vd     = 1'b0;
      bus_if.rx_sop    = 1'b0;
      bus_if.rx_eop    = 1'b0;
      bus_if.rx_data   = '0;
      bus_if.ad_switch = 1'b0;
      tick(3);
      check("rst_acq_en", bus_if.ad_acq_en, 0);
      check("rst_chn", bus_if.ad_chn, 0);
      check("rst_tx_vd", bus_if.tx_vd, 0);
      check("rst_ad_rd", bus_if.ad_rd, 0);
      check("rst_eop", bus_if.tx_eop, 0);
      check("rst_addr", bus_if.tx_addr, 0);
      check("rst_ovr", bus_if.overrun_cnt, 0);
      rst = 1'b0;
      tick(2);

      // 1: handshake
      send_cmd(T_HS, 16'h3030);
      check_ack("hs", T_HS, PF_OK, C01);
      check("hs_len", eop_len, 3);

      // 2: START channel 5, three data frames
      send_cmd(T_START, 16'h3530);
      check_ack("start5", T_START, PF_OK, C01);
      check("start5_acq", bus_if.ad_acq_en, 1);
      check("start5_chn", bus_if.ad_chn, 5);
      for (int f = 0; f < 3; f++) begin
         snap = adc_idx;
         ad_pulse();
         check_data($sformatf("frm%0d", f), f + 1, 16'h3530, 32'(f), snap);
      end

      // 3: STOP, bad channels, STOP with err, unknown type, disabled ad_switch
      send_cmd(T_STOP, 16'h3030);
      check_ack("stop", T_STOP, PF_OK, C11);
      check("stop_acq", bus_if.ad_acq_en, 0);
      send_cmd(T_START, 16'h4730);
      check_ack("start_0G", T_START, PF_BAD, C02);
      check("start_0G_acq", bus_if.ad_acq_en, 0);
      send_cmd(T_START, 16'h3930);
      check_ack("start_09", T_START, PF_BAD, C02);
      check("start_09_acq", bus_if.ad_acq_en, 0);
      check("start_09_chn", bus_if.ad_chn, 5);
      send_cmd(T_STOP, 16'h4730);
      check_ack("stop_err", T_STOP, PF_BAD, C12);
      send_cmd(16'h5A37, 16'h3030);
      check_ack("unknown", 16'h5A37, PF_BAD, CEE);
      n = eop_cnt;
      ad_pulse();
      tick(600);
      check("disabled_no_frame", eop_cnt, n);

      // 4: overrun while a frame is in flight
      send_cmd(T_START, 16'h3330);
      check_ack("start3", T_START, PF_OK, C01);
      snap = adc_idx;
      ad_pulse();
      tick(30);
      ad_pulse();
      tick(5);
      ad_pulse();
      tick(2);
      check("overrun_cnt", bus_if.overrun_cnt, 1);
      check_data("ovr_frm0", 1, 16'h3330, 32'd0, snap);
      snap = adc_idx;
      check_data("ovr_frm1", 2, 16'h3330, 32'd1, snap);
      n = eop_cnt;
      tick(700);
      check("ovr_no_extra", eop_cnt, n);
      send_cmd(T_STOP, 16'h3030);
      check_ack("stop2", T_STOP, PF_OK, C11);

      // 5: RX timeout boundary
      n = eop_cnt;
      rx_sop();
      rx_word(HEAD);
      tick(4096);
      rx_word(T_HS);
      rx_word(16'h3030);
      rx_eop();
      tick(20);
      check("timeout_no_ack", eop_cnt, n);
      rx_sop();
      rx_word(HEAD);
      rx_word(T_HS);
      rx_word(16'h3030);
      tick(4095);
      rx_eop();
      check_ack("under_timeout", T_HS, PF_OK, C01);
      send_cmd(T_HS, 16'h3030);
      check_ack("hs_after_to", T_HS, PF_OK, C01);

      // 6: reset in the middle of a data frame
      send_cmd(T_START, 16'h3230);
      check_ack("start2", T_START, PF_OK, C01);
      ad_pulse();
      tick(100);
      n = eop_cnt;
      rst = 1'b1;
      tick(2);
      check("mid_rst_tx_vd", bus_if.tx_vd, 0);
      check("mid_rst_ad_rd", bus_if.ad_rd, 0);
      check("mid_rst_acq", bus_if.ad_acq_en, 0);
      check("mid_rst_ovr", bus_if.overrun_cnt, 0);
      check("mid_rst_addr", bus_if.tx_addr, 0);
      rst = 1'b0;
      tick(600);
      check("mid_rst_no_eop", eop_cnt, n);
      send_cmd(T_START, 16'h3230);
      check_ack("start2b", T_START, PF_OK, C01);
      snap = adc_idx;
      ad_pulse();
      check_data("post_rst", 1, 16'h3230, 32'd0, snap);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
